// File: rtl/app_mult_gen.sv
// ---------------------------------------------------------------------------
// app_mult_gen -- sequential approximate unsigned multiplier.
//
// Each operand is normalised by left-shifting until its MSB is set while the
// shift amount is counted. The top K bits of each normalised operand are then
// multiplied, and the product is placed at the top of a 2W-bit register. It is
// then shifted right once per cycle to undo both normalisations. When K = W
// the result is exact.
//
// Optional build macro:
//   APP_MULT_ROUND_EN - round each K-bit top up when the bit just below the
//                       kept field is set, saturating at all ones. Timing is
//                       unchanged.
//
// Parameters:
//   W - operand width (4..32)
//   K - retained significant bits per operand (2..W)
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   start  - request pulse, sampled only while idle
//   a, b   - unsigned operands, captured on an accepted start
//   busy   - high whenever not idle
//   done   - one-cycle pulse marking a valid result
//   result - approximate product, held from done until the next accepted start
// ---------------------------------------------------------------------------
module app_mult_gen #(
    parameter int unsigned W = 16,
    parameter int unsigned K = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result
);

    // Shift counters hold up to W-1; the down counter holds up to 2W-2.
    localparam int unsigned SaW  = $clog2(W);
    localparam int unsigned CntW = $clog2(2 * W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StNormA,
        StNormB,
        StMult,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [SaW-1:0]     sa_q, sa_d;
    logic [SaW-1:0]     sb_q, sb_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*W-1:0]     result_q, result_d;

    logic [CntW-1:0]    shift_sum;
    logic [K-1:0]       ta, tb;
    logic [2*K-1:0]     prod;
    logic [2*W-1:0]     prod_placed;

    assign shift_sum = CntW'(sa_q) + CntW'(sb_q);

    // Top-K extraction, optional rounding, and product placement.
`ifdef APP_MULT_ROUND_EN
    // A zero is appended below the LSB. When K = W, the round bit then falls
    // on this zero and rounding is never applied.
    logic [W:0] a_ext, b_ext;
    assign a_ext = {a_q, 1'b0};
    assign b_ext = {b_q, 1'b0};

    always_comb begin
        ta = a_q[W-1 -: K];
        tb = b_q[W-1 -: K];
        if (a_ext[W-K] && (ta != {K{1'b1}})) begin
            ta = ta + 1'b1;
        end
        if (b_ext[W-K] && (tb != {K{1'b1}})) begin
            tb = tb + 1'b1;
        end
    end
`else
    always_comb begin
        ta = a_q[W-1 -: K];
        tb = b_q[W-1 -: K];
    end
`endif

    assign prod        = (2*K)'(ta) * (2*K)'(tb);
    assign prod_placed = (2*W)'(prod) << (2 * W - 2 * K);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sa_d    = '0;
                    sb_d    = '0;
                    state_d = StNormA;
                end
            end
            StNormA: begin
                if (a_q == '0) begin
                    result_d = '0;
                    state_d  = StDone;
                end else if (a_q[W-1]) begin
                    state_d = StNormB;
                end else begin
                    a_d  = a_q << 1;
                    sa_d = sa_q + 1'b1;
                end
            end
            StNormB: begin
                if (b_q == '0) begin
                    result_d = '0;
                    state_d  = StDone;
                end else if (b_q[W-1]) begin
                    state_d = StMult;
                end else begin
                    b_d  = b_q << 1;
                    sb_d = sb_q + 1'b1;
                end
            end
            StMult: begin
                result_d = prod_placed;
                cnt_d    = shift_sum;
                state_d  = (shift_sum == '0) ? StDone : StShift;
            end
            StShift: begin
                result_d = result_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                // The last shift happens on the cycle in which the counter hits zero.
                if (cnt_q == CntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        busy   = (state_q != StIdle);
        done   = (state_q == StDone);
        result = result_q;
    end

endmodule

// File: tb/tb_app_mult_gen.sv
module tb_app_mult_gen;

    localparam int unsigned W = 16;
    localparam int unsigned K = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [2*W-1:0] result;

    int tests;
    int fails;

    // Scoreboard: expected result and done latency, pushed at issue time.
    logic [31:0] exp_q[$];
    int          lat_q[$];

    app_mult_gen #(
        .W(W),
        .K(K)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: normalise, keep top 8 bits, optionally round, multiply, denormalise.
    function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                  output logic [31:0] r, output int lat);
        int          sa;
        int          sb;
        logic [15:0] an;
        logic [15:0] bn;
        logic [7:0]  ta;
        logic [7:0]  tb;
        logic [31:0] p;
        sa = 0;
        sb = 0;
        if (av == 16'h0) begin
            r   = 32'h0;
            lat = 2;
            return;
        end
        an = av;
        while (!an[15]) begin
            an = an << 1;
            sa++;
        end
        if (bv == 16'h0) begin
            r   = 32'h0;
            lat = sa + 3;
            return;
        end
        bn = bv;
        while (!bn[15]) begin
            bn = bn << 1;
            sb++;
        end
        ta = an[15:8];
        tb = bn[15:8];
`ifdef APP_MULT_ROUND_EN
        if (an[7] && ta != 8'hFF) ta = ta + 8'h1;
        if (bn[7] && tb != 8'hFF) tb = tb + 8'h1;
`endif
        p   = 32'(ta) * 32'(tb);
        p   = p << 16;
        r   = p >> (sa + sb);
        lat = 2 * (sa + sb) + 4;
    endfunction

    task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                         input logic [31:0] er, input int el);
        exp_q.push_back(er);
        lat_q.push_back(el);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue_model(input logic [15:0] av, input logic [15:0] bv);
        logic [31:0] er;
        int          el;
        model(av, bv, er, el);
        issue(av, bv, er, el);
    endtask

    // Called in cycle 1 after the accepting edge. With poke set, start is
    // pulsed in the shift phase (cycle 30) and again during the done cycle.
    task automatic wait_done(input string tag, input bit poke);
        logic [31:0] er;
        int          el;
        int          n;
        bit          busy_ok;
        er      = exp_q.pop_front();
        el      = lat_q.pop_front();
        n       = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 300) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke && n == 30) begin
                start = 1'b1;
                a     = 16'h1111;
                b     = 16'h2222;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (busy !== 1'b1) busy_ok = 1'b0;
        chk({tag, " done"}, 64'(done), 64'(1));
        chk({tag, " latency"}, 64'(n), 64'(el));
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " busy"}, 64'(busy_ok), 64'(1));
        if (poke) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, " done pulse"}, 64'(done), 64'(0));
        chk({tag, " idle"}, 64'(busy), 64'(0));
        chk({tag, " held"}, 64'(result), 64'(er));
    endtask

    initial begin
        bit saw_done;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset result", 64'(result), 64'(0));
        rst = 1'b0;

        issue(16'h0300, 16'h0005, 32'h0000_0F00, 42);
        wait_done("v0300x0005", 1'b0);

        issue(16'hFFFF, 16'hFFFF, 32'hFE01_0000, 4);
        wait_done("vFFFFxFFFF", 1'b0);

`ifdef APP_MULT_ROUND_EN
        issue(16'h0181, 16'h0001, 32'h0000_0182, 2 * (7 + 15) + 4);
`else
        issue(16'h0181, 16'h0001, 32'h0000_0180, 2 * (7 + 15) + 4);
`endif
        wait_done("v0181x0001", 1'b0);

        issue(16'h0000, 16'h1234, 32'h0, 2);
        wait_done("v0000x1234", 1'b0);

        issue(16'h8000, 16'h0000, 32'h0, 3);
        wait_done("v8000x0000", 1'b0);

        // Starts during SHIFT and DONE are ignored; the next idle start is accepted.
        issue(16'h0300, 16'h0005, 32'h0000_0F00, 42);
        wait_done("ignore_start", 1'b1);
        issue(16'hFFFF, 16'hFFFF, 32'hFE01_0000, 4);
        wait_done("after_ignore", 1'b0);

        // Reset mid-shift abandons the operation.
        issue(16'h0300, 16'h0005, 32'h0000_0F00, 42);
        void'(exp_q.pop_front());
        void'(lat_q.pop_front());
        repeat (28) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst busy", 64'(busy), 64'(0));
        chk("midrst done", 64'(done), 64'(0));
        chk("midrst result", 64'(result), 64'(0));
        saw_done = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst no done", 64'(saw_done), 64'(0));
        issue(16'h0300, 16'h0005, 32'h0000_0F00, 42);
        wait_done("after_rst", 1'b0);

        // A few model-driven operand pairs of varied magnitude.
        for (int i = 0; i < 6; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            rb = 16'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            issue_model(ra, rb);
            wait_done("random", 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
